sensor_emu_rx: RTL and testbench

- LVDS-side receiver/checker for the sensor-emulator frame stream.
- Consumes the LVDS bus (idle pattern, 16-cycle header, data cells, 4-cycle footer) and tracks frame timing.
- Recovers the per-frame PATTERN_WIDTH data pattern and emits it on an AXI-Stream master.
- Checks every cycle against the protocol, so loopback benches and hardware can self-verify the emulator.

---
 rtl/sensor_emu_rx.sv | 214 +++++++++++++++++++++
 tb/tb_sensor_emu_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_emu_rx.sv
// sensor_emu_rx: receiver/checker for the sensor-emulator LVDS frame stream.
// Locks onto the header after the idle pattern and follows frame timing by cycle
// number. It rebuilds the 64-bit extended data pattern from the data cells and
// publishes one AXI-Stream beat per frame. It also counts frames and errors.
module sensor_emu_rx #(
    parameter int PATTERN_WIDTH = 32,
    parameter int LVDS_WIDTH    = 512
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     clear_errors,
    input  logic [31:0]              cycles_per_frame,
    input  logic [7:0]               idle_0,
    input  logic [7:0]               idle_1,
    input  logic [31:0]              frame_header,
    input  logic [LVDS_WIDTH-1:0]    lvds,
    output logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
    output logic                     PATTERN_TUSER,
    output logic                     PATTERN_TVALID,
    input  logic                     PATTERN_TREADY,
    output logic                     sof,
    output logic                     eof,
    output logic [31:0]              frame_count,
    output logic [31:0]              error_count,
    output logic [4:0]               err_flags
);
    localparam int NBYTES = LVDS_WIDTH / 8;
    localparam int REPS   = 64 / PATTERN_WIDTH;

    typedef enum logic [1:0] {S_HUNT, S_HDR, S_DATA, S_FTR} state_t;

    state_t      state_reg, state_next;
    logic [31:0] cycle_reg, cycle_next;
    logic [63:0] pattern_reg, pattern_next;
    logic [7:0]  written_reg, written_next;
    logic        frame_err_reg, frame_err_next;
    logic        prev_idle1_reg;
    logic        last_ftr_reg;

    logic             frame_done;
    logic [4:0]       err_now;
    logic [7:0]       cell_byte;
    logic [7:0]       hdr_byte;
    logic             hdr_numbers;
    logic [2:0]       slot;
    logic [5:0]       slot_lsb;
    logic [7:0]       slot_byte;
    logic             pattern_periodic;
    logic             frame_bad;
    logic             overflow;
    logic [4:0]       flags_set;
    logic [31:0]      err_inc;
    logic [NBYTES-1:0] lane_uniform, lane_idle1, lane_hdr0, lane_hdr_ok;

    // Only idle_1 is needed to recognise a frame start (it precedes the header).
    logic unused_idle_0;
    assign unused_idle_0 = ^idle_0;

    assign cell_byte = lvds[7:0];
    // Slot k holds pattern bits [63-8k -: 8], i.e. LSB at 8*(7-k).
    assign slot      = cycle_reg[4:2];
    assign slot_lsb  = {~slot, 3'b000};
    assign slot_byte = pattern_reg[slot_lsb +: 8];

    assign pattern_periodic = (pattern_reg == {REPS{pattern_reg[63 -: PATTERN_WIDTH]}});

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane;
            assign lane             = lvds[8*gi +: 8];
            assign lane_uniform[gi] = (lane == cell_byte);
            assign lane_idle1[gi]   = (lane == idle_1);
            assign lane_hdr0[gi]    = (lane == frame_header[7:0]);
            assign lane_hdr_ok[gi]  = (lane == (hdr_numbers ? 8'(gi) : hdr_byte));
        end
    endgenerate

    // Expected header content for the current header cycle
    always_comb begin
        hdr_byte    = 8'h00;
        hdr_numbers = 1'b0;
        case (cycle_reg)
            32'd1:   hdr_byte    = frame_header[15:8];
            32'd2:   hdr_byte    = frame_header[23:16];
            32'd3:   hdr_byte    = frame_header[31:24];
            32'd8:   hdr_numbers = 1'b1;
            default: ;
        endcase
    end

    // Next-state logic: frame timing, pattern capture and per-cycle checks
    always_comb begin
        state_next     = state_reg;
        cycle_next     = cycle_reg;
        pattern_next   = pattern_reg;
        written_next   = written_reg;
        frame_err_next = frame_err_reg;
        err_now        = 5'b0;
        frame_done     = 1'b0;
        case (state_reg)
            S_HUNT: begin
                if (enable && (&lane_hdr0) && (prev_idle1_reg || last_ftr_reg)) begin
                    state_next     = S_HDR;
                    cycle_next     = 32'd1;
                    frame_err_next = 1'b0;
                    written_next   = 8'h00;
                end
            end
            S_HDR: begin
                if (!(&lane_hdr_ok)) err_now[1] = 1'b1;
                cycle_next = cycle_reg + 32'd1;
                if (cycle_reg == 32'd15) state_next = S_DATA;
            end
            S_DATA: begin
                if (!(&lane_uniform)) err_now[0] = 1'b1;
                if ((cycle_reg <= 32'd47) && !written_reg[slot]) begin
                    pattern_next[slot_lsb +: 8] = cell_byte;
                    written_next[slot]          = 1'b1;
                end else if (cell_byte != slot_byte) begin
                    err_now[2] = 1'b1;
                end
                cycle_next = cycle_reg + 32'd1;
                if (cycle_reg == cycles_per_frame - 32'd5) state_next = S_FTR;
            end
            S_FTR: begin
                if (|lvds) err_now[3] = 1'b1;
                if (cycle_reg == cycles_per_frame - 32'd1) begin
                    frame_done = 1'b1;
                    state_next = S_HUNT;
                    cycle_next = 32'd0;
                end else begin
                    cycle_next = cycle_reg + 32'd1;
                end
            end
            default: state_next = S_HUNT;
        endcase
        frame_err_next = frame_err_next | (|err_now);
        // Disarming aborts any frame in flight without counting it.
        if (!enable && (state_reg != S_HUNT)) begin
            state_next = S_HUNT;
            cycle_next = 32'd0;
            err_now    = 5'b0;
            frame_done = 1'b0;
        end
    end

    assign frame_bad = frame_err_next | ~pattern_periodic;
    assign overflow  = frame_done && PATTERN_TVALID && !PATTERN_TREADY;
    assign flags_set = err_now | {overflow, 1'b0, frame_done && !pattern_periodic, 2'b00};
    assign err_inc   = frame_done ? (32'(frame_bad) + 32'(overflow)) : 32'd0;

    assign sof = (state_reg == S_HDR);
    assign eof = (state_reg == S_FTR);

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= S_HUNT;
        else         state_reg <= state_next;
    end

    // Frame tracking registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_reg      <= 32'd0;
            pattern_reg    <= 64'd0;
            written_reg    <= 8'h00;
            frame_err_reg  <= 1'b0;
            prev_idle1_reg <= 1'b0;
            last_ftr_reg   <= 1'b0;
        end else begin
            cycle_reg      <= cycle_next;
            pattern_reg    <= pattern_next;
            written_reg    <= written_next;
            frame_err_reg  <= frame_err_next;
            prev_idle1_reg <= &lane_idle1;
            last_ftr_reg   <= frame_done;
        end
    end

    // Output beat: load on publish unless a beat is still waiting, drop on handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            PATTERN_TVALID <= 1'b0;
            PATTERN_TDATA  <= '0;
            PATTERN_TUSER  <= 1'b0;
        end else if (frame_done && !overflow) begin
            PATTERN_TVALID <= 1'b1;
            PATTERN_TDATA  <= pattern_reg[63 -: PATTERN_WIDTH];
            PATTERN_TUSER  <= frame_bad;
        end else if (PATTERN_TVALID && PATTERN_TREADY) begin
            PATTERN_TVALID <= 1'b0;
        end
    end

    // Frame/error counters and sticky flags; clear_errors beats any increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= 32'd0;
            error_count <= 32'd0;
            err_flags   <= 5'b0;
        end else begin
            frame_count <= frame_count + 32'(frame_done);
            if (clear_errors) begin
                error_count <= 32'd0;
                err_flags   <= 5'b0;
            end else begin
                error_count <= error_count + err_inc;
                err_flags   <= err_flags | flags_set;
            end
        end
    end
endmodule

// File: tb/tb_sensor_emu_rx.sv
// tb_sensor_emu_rx: drives emulator-style frames (with optional injected faults)
// and compares the receiver against a frame-level expectation model.
module tb_sensor_emu_rx;
    localparam int LW = 512;
    localparam int PW = 32;
    localparam int NB = LW / 8;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic          clear_errors;
    logic [31:0]   cycles_per_frame;
    logic [7:0]    idle_0, idle_1;
    logic [31:0]   frame_header;
    logic [LW-1:0] lvds;
    logic [PW-1:0] tdata;
    logic          tuser, tvalid, tready;
    logic          sof, eof;
    logic [31:0]   frame_count, error_count;
    logic [4:0]    err_flags;

    sensor_emu_rx #(.PATTERN_WIDTH(PW), .LVDS_WIDTH(LW)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear_errors(clear_errors),
        .cycles_per_frame(cycles_per_frame), .idle_0(idle_0), .idle_1(idle_1),
        .frame_header(frame_header), .lvds(lvds),
        .PATTERN_TDATA(tdata), .PATTERN_TUSER(tuser), .PATTERN_TVALID(tvalid),
        .PATTERN_TREADY(tready), .sof(sof), .eof(eof),
        .frame_count(frame_count), .error_count(error_count), .err_flags(err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expectation model state
    logic [31:0] exp_frames = 0;
    logic [31:0] exp_errs   = 0;
    logic [4:0]  exp_flags  = 0;
    logic [31:0] exp_tdata  = 0;
    logic        exp_tuser  = 0;
    logic        exp_held   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rep8(input logic [7:0] b);
        logic [LW-1:0] w;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = b;
        return w;
    endfunction

    // Bus word the emulator sends on frame cycle c
    function automatic logic [LW-1:0] frame_word(input int c, input int cpf, input logic [63:0] pat);
        logic [LW-1:0] w;
        int k;
        w = '0;
        if (c <= 3) begin
            w = rep8(frame_header[8*c +: 8]);
        end else if (c == 8) begin
            for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'(i);
        end else if (c >= 16 && c <= cpf - 5) begin
            k = (c / 4) % 8;
            w = rep8(pat[63 - 8*k -: 8]);
        end
        return w;
    endfunction

    // Idle pattern, always ending on idle_1 so a header may follow
    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            lvds = (((n - 1 - i) % 2) == 0) ? rep8(idle_1) : rep8(idle_0);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [63:0] pat, input int cpf, input int stop_at,
                              input int kind, input int ccyc, input int cbyte,
                              input logic [7:0] cxor, input logic clr_last);
        cycles_per_frame = cpf;
        for (int c = 0; c < stop_at; c++) begin
            logic [LW-1:0] w;
            w = frame_word(c, cpf, pat);
            if (kind != 0 && c == ccyc) w[8*cbyte +: 8] = w[8*cbyte +: 8] ^ cxor;
            lvds = w;
            clear_errors = clr_last && (c == cpf - 1);
            @(posedge clk); #1;
            clear_errors = 1'b0;
            if (c == 0) check_eq("sof", sof, 1);
            if (c == cpf - 5) check_eq("eof", eof, 1);
        end
    endtask

    task automatic model_frame(input logic bad, input logic [4:0] fl, input logic [63:0] pat);
        exp_frames = exp_frames + 1;
        if (exp_held) begin
            exp_errs  = exp_errs + 1;
            exp_flags = exp_flags | 5'b10000;
        end else begin
            exp_tdata = pat[63 -: PW];
            exp_tuser = bad;
        end
        exp_errs  = exp_errs + 32'(bad);
        exp_flags = exp_flags | fl;
        exp_held  = 1'b1;
    endtask

    task automatic check_beat();
        check_eq("tvalid", tvalid, 1);
        check_eq("tdata", tdata, exp_tdata);
        check_eq("tuser", tuser, exp_tuser);
        check_eq("frame_count", frame_count, exp_frames);
        check_eq("error_count", error_count, exp_errs);
        check_eq("err_flags", err_flags, exp_flags);
        $display("frame %0d: tdata=0x%08h tuser=%0d errors=%0d flags=%05b",
                 frame_count, tdata, tuser, error_count, err_flags);
    endtask

    task automatic run_frame(input logic [63:0] pat, input int cpf, input int kind,
                             input int ccyc, input int cbyte, input logic [7:0] cxor,
                             input logic bad, input logic [4:0] fl);
        send_frame(pat, cpf, cpf, kind, ccyc, cbyte, cxor, 1'b0);
        model_frame(bad, fl, pat);
        check_beat();
        if (tready) exp_held = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tvalid"}, tvalid, 0);
        check_eq({tag, "_tdata"}, tdata, 0);
        check_eq({tag, "_tuser"}, tuser, 0);
        check_eq({tag, "_frames"}, frame_count, 0);
        check_eq({tag, "_errors"}, error_count, 0);
        check_eq({tag, "_flags"}, err_flags, 0);
        check_eq({tag, "_sof"}, sof, 0);
        check_eq({tag, "_eof"}, eof, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] pat;
        logic [31:0] p32;
        int cpf, kind, ccyc, cbyte, gap;
        logic [7:0] cxor;
        logic [4:0] fl;

        resetn = 0; enable = 0; clear_errors = 0; cycles_per_frame = 64;
        idle_0 = 8'hA5; idle_1 = 8'h5A; frame_header = 32'h44332211;
        lvds = '0; tready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1; enable = 1; tready = 1;

        // Directed clean frame
        send_idle(4);
        run_frame({2{32'hDEADBEEF}}, 64, 0, 0, 0, 8'h00, 1'b0, 5'b00000);

        // Back-to-back frames with the sink stalled: second is dropped
        send_idle(4);
        tready = 0;
        run_frame({2{32'h11111111}}, 64, 0, 0, 0, 8'h00, 1'b0, 5'b00000);
        run_frame({2{32'h22222222}}, 64, 0, 0, 0, 8'h00, 1'b0, 5'b00000);
        tready = 1;
        @(posedge clk); #1;
        exp_held = 1'b0;
        check_eq("tvalid_drain", tvalid, 0);

        // Directed corruptions: header byte_numbers, data cell, top lane only
        send_idle(4);
        run_frame({2{32'hCAFEF00D}}, 64, 1, 8, 3, 8'hFC, 1'b1, 5'b00010);
        send_idle(4);
        run_frame({2{32'h0BADC0DE}}, 64, 2, 50, 0, 8'h5C, 1'b1, 5'b00101);
        send_idle(4);
        run_frame({2{32'h13579BDF}}, 64, 3, 50, NB - 1, 8'h81, 1'b1, 5'b00001);

        // Randomized frames: random length, pattern, fault and gap
        for (int f = 0; f < 24; f++) begin
            cpf   = 52 + 2 * $urandom_range(0, 14);
            p32   = $urandom;
            pat   = {p32, p32};
            kind  = $urandom_range(0, 5);
            ccyc  = 0; cbyte = 0; cxor = 8'($urandom_range(1, 255)); fl = 5'b0;
            case (kind)
                1: begin ccyc = $urandom_range(1, 15); cbyte = $urandom_range(0, NB - 1); fl = 5'b00010; end
                2: begin
                    do ccyc = $urandom_range(16, cpf - 5);
                    while (ccyc <= 47 && (ccyc % 4) == 0);
                    cbyte = 0; fl = 5'b00101;
                end
                3: begin ccyc = $urandom_range(16, cpf - 5); cbyte = NB - 1; fl = 5'b00001; end
                4: begin ccyc = $urandom_range(cpf - 4, cpf - 1); cbyte = $urandom_range(0, NB - 1); fl = 5'b01000; end
                5: begin
                    do pat = {$urandom, $urandom};
                    while (pat[63:32] == pat[31:0]);
                    fl = 5'b00100;
                end
                default: ;
            endcase
            gap = $urandom_range(0, 3);
            if (gap > 0) send_idle(2 * gap);
            run_frame(pat, cpf, (kind == 5) ? 0 : kind, ccyc, cbyte, cxor, kind != 0, fl);
        end

        // clear_errors on the final cycle of a bad frame: clear wins
        send_idle(4);
        pat = {2{32'h600DF00D}};
        send_frame(pat, 64, 64, 4, 63, 5, 8'h01, 1'b1);
        model_frame(1'b1, 5'b01000, pat);
        exp_errs = 0; exp_flags = 0;
        check_beat();
        exp_held = 1'b0;

        // Disarm mid-frame: aborted frame is neither counted nor published
        send_idle(4);
        send_frame({2{32'hA0A0A0A0}}, 64, 21, 0, 0, 0, 8'h00, 1'b0);
        enable = 0; lvds = '0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("abort_sof", sof, 0);
        enable = 1;
        send_idle(4);
        check_eq("abort_frames", frame_count, exp_frames);
        check_eq("abort_tvalid", tvalid, 0);
        run_frame({2{32'h5EED5EED}}, 64, 1, 2, 7, 8'h40, 1'b1, 5'b00010);

        // Reset mid-frame at cycle 30, release 3 cycles later
        send_idle(4);
        send_frame({2{32'h77777777}}, 64, 31, 0, 0, 0, 8'h00, 1'b0);
        resetn = 0;
        #1;
        check_all_zero("midreset");
        exp_frames = 0; exp_errs = 0; exp_flags = 0; exp_tdata = 0; exp_tuser = 0; exp_held = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1;
        send_idle(4);
        run_frame({2{32'hFEEDFACE}}, 64, 0, 0, 0, 8'h00, 1'b0, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
